// File: rtl/ann_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ann_pkg
//  Description : Shared widths, feeder state encoding and sample-memory
//                address helper for the ANN sample feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package ann_pkg;

    localparam int W       = 10;
    localparam int N_FEAT  = 30;
    localparam int N_OUT   = 3;
    localparam int N_WORDS = N_FEAT + N_OUT;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_NEXT      = 3'd4,
        S_FINISH    = 3'd5,
        S_ERROR     = 3'd6
    } feeder_state_t;

    // Sample s occupies N_WORDS consecutive words; targets follow the features.
    function automatic int unsigned word_addr(input int unsigned s, input int unsigned k);
        return s * N_WORDS + k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ann_sample_ram.sv
`default_nettype none
// ============================================================================
//  Module      : ann_sample_ram
//  Description : Sample store, one write port and one registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ann_sample_ram #(
    parameter int DW    = 10,
    parameter int DEPTH = 528,
    parameter int AW    = 10
) (
    input  logic          Clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge Clock) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/ann_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : ann_sample_feeder
//  Description : Streams stored samples (features + targets) into the ANN
//                detector, pulsing start per sample and looping over epochs.
//  Revision    : 1.0 - initial release
// ============================================================================
module ann_sample_feeder
    import ann_pkg::*;
#(
    parameter int N_SAMP    = 16,
    parameter int MAX_EPOCH = 255,
    parameter int TIMEOUT   = 4096,
    parameter int AW        = $clog2(N_SAMP * N_WORDS)
) (
    input  logic                         Clock,
    input  logic                         Rst,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [W-1:0]                 wr_data,
    input  logic [4:0]                   num_samples,
    input  logic                         train_mode,
    input  logic                         go,
    input  logic                         abort,
    input  logic                         ann_done,
    input  logic                         ann_done_train,
    output logic [N_FEAT-1:0][W-1:0]     ann_in,
    output logic [N_OUT-1:0][W-1:0]      ann_target,
    output logic                         ann_start,
    output logic                         ann_training,
    output logic                         busy,
    output logic                         finished,
    output logic                         timeout_err,
    output logic [4:0]                   sample_idx,
    output logic [7:0]                   epoch_cnt
);

    localparam int             c_DEPTH = N_SAMP * N_WORDS;
    localparam int             c_TW    = $clog2(TIMEOUT);
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT - 1);

    feeder_state_t          r_state, w_next;
    logic [5:0]             r_k;
    logic [c_TW-1:0]        r_timer;
    logic [4:0]             r_num_samp;
    logic                   r_train;
    logic                   r_training;
    logic [4:0]             r_sample_idx;
    logic [7:0]             r_epoch;
    logic                   r_finished;
    logic                   r_timeout_err;
    logic                   r_done_q;
    logic [N_FEAT-1:0][W-1:0] r_ann_in;
    logic [N_OUT-1:0][W-1:0]  r_ann_target;

    logic                   w_done_edge;
    logic                   w_load_done;
    logic                   w_last_sample;
    logic                   w_epoch_last;
    logic [5:0]             w_rd_k;
    logic [5:0]             w_cap;
    logic [AW-1:0]          w_rd_addr;
    logic [W-1:0]           w_rd_data;
    logic                   w_wr_en;
    logic [4:0]             w_num_eff;

    assign w_wr_en       = wr_en && (r_state == S_IDLE);
    assign w_done_edge   = ann_done && !r_done_q;
    assign w_load_done   = (r_k == 6'(N_WORDS));
    assign w_last_sample = (r_sample_idx >= (r_num_samp - 5'd1));
    assign w_epoch_last  = ((9'(r_epoch) + 9'd1) == 9'(MAX_EPOCH));
    assign w_rd_k        = w_load_done ? 6'd0 : r_k;
    assign w_cap         = r_k - 6'd1;
    assign w_rd_addr     = AW'(word_addr(32'(r_sample_idx), 32'(w_rd_k)));
    assign w_num_eff     = (num_samples == 5'd0)            ? 5'd1 :
                           (num_samples > 5'(N_SAMP))       ? 5'(N_SAMP) : num_samples;

    ann_sample_ram #(
        .DW    (W),
        .DEPTH (c_DEPTH),
        .AW    (AW)
    ) u_ram (
        .Clock   (Clock),
        .wr_en   (w_wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (go) w_next = S_LOAD;
            S_LOAD:      if (w_load_done) w_next = S_START;
            S_START:     w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (ann_done_train)         w_next = S_FINISH;
                else if (w_done_edge)       w_next = S_NEXT;
                else if (r_timer == c_TMAX) w_next = S_ERROR;
            end
            S_NEXT: begin
                if (w_last_sample && (!r_train || w_epoch_last)) w_next = S_FINISH;
                else                                             w_next = S_LOAD;
            end
            S_FINISH:    w_next = S_IDLE;
            S_ERROR:     w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_timer       <= '0;
            r_num_samp    <= 5'd1;
            r_train       <= 1'b0;
            r_training    <= 1'b0;
            r_sample_idx  <= '0;
            r_epoch       <= '0;
            r_finished    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_done_q      <= 1'b0;
            r_ann_in      <= '0;
            r_ann_target  <= '0;
        end else begin
            r_state    <= w_next;
            r_done_q   <= ann_done;
            r_training <= r_train;
            r_k        <= (r_state == S_LOAD) ? r_k + 6'd1 : 6'd0;
            r_timer    <= (r_state == S_WAIT_DONE) ? r_timer + 1'b1 : '0;

            if (r_state == S_IDLE && go && !abort) begin
                r_num_samp    <= w_num_eff;
                r_train       <= train_mode;
                r_sample_idx  <= '0;
                r_epoch       <= '0;
                r_finished    <= 1'b0;
                r_timeout_err <= 1'b0;
            end

            // Read data lags the issued address by one cycle, hence slot k-1.
            if (r_state == S_LOAD && r_k != 6'd0) begin
                for (int i = 0; i < N_FEAT; i++) begin
                    if (w_cap == 6'(i)) r_ann_in[i] <= w_rd_data;
                end
                for (int i = 0; i < N_OUT; i++) begin
                    if (w_cap == 6'(N_FEAT + i)) r_ann_target[i] <= w_rd_data;
                end
            end

            if (r_state == S_NEXT && !abort) begin
                if (w_last_sample) begin
                    r_sample_idx <= '0;
                    if (r_epoch != 8'(MAX_EPOCH)) r_epoch <= r_epoch + 8'd1;
                end else begin
                    r_sample_idx <= r_sample_idx + 5'd1;
                end
            end

            if (r_state == S_FINISH) r_finished <= 1'b1;
            if (r_state == S_WAIT_DONE && w_next == S_ERROR) r_timeout_err <= 1'b1;
        end
    end

    assign ann_in       = r_ann_in;
    assign ann_target   = r_ann_target;
    assign ann_start    = (r_state == S_START);
    assign ann_training = r_training;
    assign busy         = (r_state != S_IDLE);
    assign finished     = r_finished;
    assign timeout_err  = r_timeout_err;
    assign sample_idx   = r_sample_idx;
    assign epoch_cnt    = r_epoch;

endmodule
`default_nettype wire

// File: tb/tb_ann_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ann_sample_feeder
//  Description : Directed bench for ann_sample_feeder with start-pulse scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ann_sample_feeder;
    import ann_pkg::*;

    localparam int AW      = 10;
    localparam int TIMEOUT = 4096;

    logic          Clock = 1'b0;
    logic          Rst, wr_en, wr_en2, train_mode, go, go2, abort, ann_done, ann_done_train;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [4:0]    num_samples;

    logic [N_FEAT-1:0][W-1:0] ann_in1, ann_in2;
    logic [N_OUT-1:0][W-1:0]  ann_target1, ann_target2;
    logic       start1, start2, training1, training2, busy1, busy2;
    logic       fin1, fin2, tout1, tout2;
    logic [4:0] idx1, idx2;
    logic [7:0] ep1, ep2;

    always #5 Clock = ~Clock;

    ann_sample_feeder dut1 (
        .Clock(Clock), .Rst(Rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_samples(num_samples), .train_mode(train_mode), .go(go), .abort(abort),
        .ann_done(ann_done), .ann_done_train(ann_done_train),
        .ann_in(ann_in1), .ann_target(ann_target1), .ann_start(start1),
        .ann_training(training1), .busy(busy1), .finished(fin1), .timeout_err(tout1),
        .sample_idx(idx1), .epoch_cnt(ep1)
    );

    ann_sample_feeder #(.MAX_EPOCH(2)) dut2 (
        .Clock(Clock), .Rst(Rst), .wr_en(wr_en2), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_samples(num_samples), .train_mode(train_mode), .go(go2), .abort(abort),
        .ann_done(ann_done), .ann_done_train(ann_done_train),
        .ann_in(ann_in2), .ann_target(ann_target2), .ann_start(start2),
        .ann_training(training2), .busy(busy2), .finished(fin2), .timeout_err(tout2),
        .sample_idx(idx2), .epoch_cnt(ep2)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int starts1  = 0;
    int starts2  = 0;

    typedef struct {
        int         idx;
        logic [W-1:0] f0, f29, t0, t2;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [N_FEAT*W-1:0] obs, input logic [N_FEAT*W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_word(input int s, input int k);
        int v;
        if (k < N_FEAT)  v = s * 40 + k + 1;
        else if (s == 0) v = (k == N_FEAT) ? 900 : 100;
        else             v = 100 + s * 10 + (k - N_FEAT);
        return W'(v);
    endfunction

    task automatic push(input bit sec, input int s);
        exp_t e;
        e.idx = s;
        e.f0  = exp_word(s, 0);
        e.f29 = exp_word(s, N_FEAT - 1);
        e.t0  = exp_word(s, N_FEAT);
        e.t2  = exp_word(s, N_FEAT + 2);
        if (sec) q2.push_back(e);
        else     q1.push_back(e);
    endtask

    // Scoreboards: each start pulse must match the oldest pending expectation.
    always @(negedge Clock) begin : mon1
        exp_t e;
        if (start1 === 1'b1) begin
            starts1++;
            n_assert++;
            assert (q1.size() != 0) else begin
                n_fail++;
                $error("FAIL sb1_pending: observed start with %0d queued, expected >0", q1.size());
            end
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("sb1_idx", 32'(idx1), 32'(e.idx));
                chk("sb1_f0",  32'(ann_in1[0]), 32'(e.f0));
                chk("sb1_f29", 32'(ann_in1[N_FEAT-1]), 32'(e.f29));
                chk("sb1_t0",  32'(ann_target1[0]), 32'(e.t0));
                chk("sb1_t2",  32'(ann_target1[2]), 32'(e.t2));
            end
        end
    end

    always @(negedge Clock) begin : mon2
        exp_t e;
        if (start2 === 1'b1) begin
            starts2++;
            n_assert++;
            assert (q2.size() != 0) else begin
                n_fail++;
                $error("FAIL sb2_pending: observed start with %0d queued, expected >0", q2.size());
            end
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("sb2_idx", 32'(idx2), 32'(e.idx));
                chk("sb2_f0",  32'(ann_in2[0]), 32'(e.f0));
                chk("sb2_t2",  32'(ann_target2[2]), 32'(e.t2));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic wait_start(input bit sec);
        int n = 0;
        while (n < 200 && ((sec ? start2 : start1) !== 1'b1)) begin
            @(negedge Clock);
            n++;
        end
        n_assert++;
        assert (n < 200) else begin
            n_fail++;
            $error("FAIL wait_start: waited %0d cycles, expected <200", n);
        end
    endtask

    task automatic wait_idle(input bit sec);
        int n = 0;
        while (n < 6000 && ((sec ? busy2 : busy1) === 1'b1)) begin
            @(negedge Clock);
            n++;
        end
        n_assert++;
        assert (n < 6000) else begin
            n_fail++;
            $error("FAIL wait_idle: waited %0d cycles, expected <6000", n);
        end
    endtask

    task automatic do_pass(input bit sec, input bit conv);
        wait_start(sec);
        cyc(3);
        ann_done       = 1'b1;
        ann_done_train = conv;
        cyc(1);
        ann_done       = 1'b0;
        ann_done_train = 1'b0;
    endtask

    task automatic launch(input bit sec, input int ns, input bit tm);
        num_samples = 5'(ns);
        train_mode  = tm;
        if (sec) go2 = 1'b1;
        else     go  = 1'b1;
        cyc(1);
        go  = 1'b0;
        go2 = 1'b0;
    endtask

    logic [N_FEAT*W-1:0] exp_feat;
    int                  n;
    int                  s_before;

    initial begin
        Rst = 1'b1; wr_en = 1'b0; wr_en2 = 1'b0; wr_addr = '0; wr_data = '0;
        num_samples = '0; train_mode = 1'b0; go = 1'b0; go2 = 1'b0; abort = 1'b0;
        ann_done = 1'b0; ann_done_train = 1'b0;
        cyc(3);
        Rst = 1'b0;
        cyc(1);

        // Reset state
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_finished", 32'(fin1), 0);
        chk("rst_timeout", 32'(tout1), 0);
        chk("rst_start", 32'(start1), 0);
        chk("rst_idx", 32'(idx1), 0);
        chk("rst_epoch", 32'(ep1), 0);
        chk("rst_training", 32'(training1), 0);
        chk_wide("rst_ann_in", ann_in1, '0);
        chk("rst_target", 32'(ann_target1), 0);

        // Fill samples 0..2 into both feeders
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < N_WORDS; k++) begin
                wr_en = 1'b1; wr_en2 = 1'b1;
                wr_addr = AW'(word_addr(s, k));
                wr_data = exp_word(s, k);
                cyc(1);
            end
        end
        wr_en = 1'b0; wr_en2 = 1'b0;

        // Single inference pass; cycle 1 is the cycle go is presented
        push(0, 0);
        num_samples = 5'd1; train_mode = 1'b0; go = 1'b1;
        n = 1;
        cyc(1);
        go = 1'b0;
        n++;
        while (n < 80 && start1 !== 1'b1) begin
            cyc(1);
            n++;
        end
        chk("go_to_start_cycle", 32'(n), 36);
        cyc(10);
        ann_done = 1'b1;
        cyc(1);
        ann_done = 1'b0;
        wait_idle(0);
        chk("t1_finished", 32'(fin1), 1);
        chk("t1_epoch", 32'(ep1), 1);
        chk("t1_idx", 32'(idx1), 0);
        chk("t1_starts", 32'(starts1), 1);
        chk("t1_timeout", 32'(tout1), 0);
        for (int k = 0; k < N_FEAT; k++) exp_feat[k*W +: W] = exp_word(0, k);
        chk_wide("t1_ann_in", ann_in1, exp_feat);
        for (int t = 0; t < N_OUT; t++)
            chk($sformatf("t1_target%0d", t), 32'(ann_target1[t]), 32'(exp_word(0, N_FEAT + t)));

        // Training over 3 samples; 5th pass raises done edge and converged together
        push(0, 0); push(0, 1); push(0, 2); push(0, 0); push(0, 1);
        launch(0, 3, 1'b1);
        cyc(1);
        chk("t2_finished_cleared", 32'(fin1), 0);
        chk("t2_busy", 32'(busy1), 1);
        for (int p = 0; p < 4; p++) do_pass(0, 1'b0);
        do_pass(0, 1'b1);
        wait_idle(0);
        chk("t2_starts", 32'(starts1), 6);
        chk("t2_finished", 32'(fin1), 1);
        chk("t2_epoch", 32'(ep1), 1);
        chk("t2_idx_unchanged", 32'(idx1), 1);
        chk("t2_training", 32'(training1), 1);

        // ann_done already high before start never produces an edge
        push(0, 0);
        ann_done = 1'b1;
        launch(0, 1, 1'b0);
        wait_start(0);
        n = 0;
        while (n < 5000 && tout1 !== 1'b1) begin
            cyc(1);
            n++;
        end
        // TIMEOUT cycles spent in WAIT_DONE, flag visible the cycle after
        chk("t3_timeout_latency", 32'(n), TIMEOUT + 1);
        wait_idle(0);
        ann_done = 1'b0;
        chk("t3_busy", 32'(busy1), 0);
        chk("t3_timeout", 32'(tout1), 1);
        chk("t3_finished", 32'(fin1), 0);
        chk("t3_epoch", 32'(ep1), 0);

        // Abort in LOAD cycle 12, with a write attempted while busy
        s_before = starts1;
        launch(0, 1, 1'b0);
        chk("t5_timeout_cleared", 32'(tout1), 0);
        chk("t5_busy", 32'(busy1), 1);
        wr_en = 1'b1; wr_addr = '0; wr_data = 10'd555;
        cyc(1);
        wr_en = 1'b0;
        cyc(10);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("t5_abort_idle", 32'(busy1), 0);
        go = 1'b1; abort = 1'b1;
        cyc(1);
        go = 1'b0; abort = 1'b0;
        chk("t5_abort_beats_go", 32'(busy1), 0);
        cyc(2);
        chk("t5_no_start", 32'(starts1), 32'(s_before));

        // Rst during WAIT_DONE; scoreboard confirms the busy write was dropped
        push(0, 0);
        launch(0, 1, 1'b0);
        wait_start(0);
        cyc(3);
        Rst = 1'b1;
        cyc(1);
        Rst = 1'b0;
        chk("t5_rst_busy", 32'(busy1), 0);
        chk("t5_rst_idx", 32'(idx1), 0);
        chk("t5_rst_epoch", 32'(ep1), 0);
        chk("t5_rst_finished", 32'(fin1), 0);
        chk("t5_rst_timeout", 32'(tout1), 0);
        chk("t5_rst_training", 32'(training1), 0);
        chk("t5_rst_start", 32'(start1), 0);
        chk_wide("t5_rst_ann_in", ann_in1, '0);
        chk("t5_rst_target", 32'(ann_target1), 0);

        // Epoch limit of 2 on the second instance
        s_before = starts1;
        push(1, 0); push(1, 1); push(1, 0); push(1, 1);
        launch(1, 2, 1'b1);
        for (int p = 0; p < 4; p++) do_pass(1, 1'b0);
        wait_idle(1);
        chk("t6_starts", 32'(starts2), 4);
        chk("t6_epoch", 32'(ep2), 2);
        chk("t6_finished", 32'(fin2), 1);
        chk("t6_idx", 32'(idx2), 0);
        chk("t6_dut1_quiet", 32'(starts1), 32'(s_before));

        cyc(2);
        chk("sb1_drained", 32'(q1.size()), 0);
        chk("sb2_drained", 32'(q2.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
